test_logic_vec_checker: RTL and testbench

- Parametrised self-checking stimulus/checker harness for bitwise logic DUTs in the CI test flow.
- Replaces per-op, single-vector benches.
- Drives NUM_VEC deterministic operand pairs into a DUT of configurable width and pipeline latency, computes expected results with an internal reference model, and compares the DUT output LATENCY cycles later.
- Reports sticky fail, finish, mismatch count and first failing vector index.

---
 rtl/test_logic_vec_checker.sv | 248 ++++++++++++++++++++++++
 tb/tb_test_logic_vec_checker.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_logic_vec_checker.sv
// -----------------------------------------------------------------------------
// test_logic_vec_checker
//
// Self-checking stimulus/checker harness for bitwise logic DUTs. It drives
// NUM_VEC deterministic operand pairs (arithmetic sequences from A_BASE/B_BASE
// stepping by A_STEP/B_STEP, wrapping silently mod 2^WIDTH) into a DUT. It
// computes each expected result with an internal reference op and compares the
// DUT result LATENCY enabled cycles after the operands were presented.
//
// Handshake / flow control: there is no valid/ready pair. A single advance
// enable 'en' qualifies every edge. When en=0, operands, the expectation delay
// line, the state and all outputs hold, and y is not compared. The same en must
// gate the DUT pipeline so both sides stay in lock-step.
//
// Parameters:
//   WIDTH    operand/result width (1..32)
//   NUM_VEC  number of vectors driven (1..65535)
//   LATENCY  DUT latency in enabled cycles (0 = combinational DUT, 0..8)
//   OP       reference op: 0 AND, 1 OR, 2 XOR, 3 XNOR
//   A_BASE / B_BASE  first operands
//   A_STEP / B_STEP  per-vector increments
//
// Ports:
//   clock          clock
//   reset          synchronous, active-high reset
//   en             advance enable (also gates the DUT pipeline)
//   y              DUT result
//   a, b           registered operands to the DUT
//   fail           sticky: at least one mismatch seen
//   finish         sticky: all NUM_VEC checks retired
//   err_count      saturating mismatch count
//   first_err_idx  index of first mismatching vector, 16'hFFFF if none
// -----------------------------------------------------------------------------
module test_logic_vec_checker #(
    parameter int WIDTH   = 8,
    parameter int NUM_VEC = 4,
    parameter int LATENCY = 0,
    parameter int OP      = 1,
    parameter int A_BASE  = 3,
    parameter int B_BASE  = 8,
    parameter int A_STEP  = 1,
    parameter int B_STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             fail,
    output logic             finish,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    // A combinational DUT needs no delay line; keep one dummy slot so the
    // arrays stay legal, and bypass it in the check mux below.
    localparam int DL_DEPTH = (LATENCY == 0) ? 1 : LATENCY;

    localparam logic [WIDTH-1:0] A_INIT   = WIDTH'(A_BASE);
    localparam logic [WIDTH-1:0] B_INIT   = WIDTH'(B_BASE);
    localparam logic [WIDTH-1:0] A_INC    = WIDTH'(A_STEP);
    localparam logic [WIDTH-1:0] B_INC    = WIDTH'(B_STEP);
    localparam logic [15:0]      LAST_IDX = 16'(NUM_VEC - 1);
    localparam logic [15:0]      NO_ERR   = 16'hFFFF;
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    // RUN   : presenting vectors, one per enabled edge
    // DRAIN : all vectors presented, waiting for in-flight checks to retire
    // DONE  : finished, frozen until reset
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      vec_idx_q, vec_idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             fail_q, fail_d;
    logic             finish_q, finish_d;
    logic [15:0]      err_count_q, err_count_d;
    logic [15:0]      first_err_idx_q, first_err_idx_d;

    // Expectation delay line: slot 0 is the newest entry, slot DL_DEPTH-1 is
    // the entry whose check is due in the current enabled cycle.
    logic             dl_valid_q [DL_DEPTH];
    logic             dl_valid_d [DL_DEPTH];
    logic [WIDTH-1:0] dl_exp_q   [DL_DEPTH];
    logic [WIDTH-1:0] dl_exp_d   [DL_DEPTH];
    logic [15:0]      dl_idx_q   [DL_DEPTH];
    logic [15:0]      dl_idx_d   [DL_DEPTH];

    // Check-side signals
    logic [WIDTH-1:0] cur_exp;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_exp;
    logic [15:0]      chk_idx;
    logic             active;
    logic             chk_fire;
    logic             mismatch;

    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (OP)
            0:       r = x & z;
            1:       r = x | z;
            2:       r = x ^ z;
            default: r = ~(x ^ z);
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Check selection: with LATENCY=0 the currently presented vector is
    // checked directly; otherwise the oldest delay-line entry is due.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_exp = ref_op(a_q, b_q);
        if (LATENCY == 0) begin
            chk_valid = (state_q == ST_RUN);
            chk_exp   = cur_exp;
            chk_idx   = vec_idx_q;
        end else begin
            chk_valid = dl_valid_q[DL_DEPTH-1];
            chk_exp   = dl_exp_q[DL_DEPTH-1];
            chk_idx   = dl_idx_q[DL_DEPTH-1];
        end
        active   = en && (state_q != ST_DONE);
        chk_fire = active && chk_valid;
        mismatch = chk_fire && (y != chk_exp);
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        vec_idx_d       = vec_idx_q;
        a_d             = a_q;
        b_d             = b_q;
        fail_d          = fail_q;
        finish_d        = finish_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        for (int i = 0; i < DL_DEPTH; i++) begin
            dl_valid_d[i] = dl_valid_q[i];
            dl_exp_d[i]   = dl_exp_q[i];
            dl_idx_d[i]   = dl_idx_q[i];
        end

        if (active) begin
            // Shift the delay line; DRAIN pushes bubbles (valid=0).
            for (int i = DL_DEPTH - 1; i > 0; i--) begin
                dl_valid_d[i] = dl_valid_q[i-1];
                dl_exp_d[i]   = dl_exp_q[i-1];
                dl_idx_d[i]   = dl_idx_q[i-1];
            end
            dl_valid_d[0] = (state_q == ST_RUN);
            dl_exp_d[0]   = cur_exp;
            dl_idx_d[0]   = vec_idx_q;

            if (mismatch) begin
                fail_d = 1'b1;
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + 16'd1;
                end
                if (first_err_idx_q == NO_ERR) begin
                    first_err_idx_d = chk_idx;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (vec_idx_q == LAST_IDX) begin
                        // Last vector presented: operands hold from here on.
                        // A combinational DUT has just had its final check.
                        if (LATENCY == 0) begin
                            state_d  = ST_DONE;
                            finish_d = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        a_d       = a_q + A_INC;
                        b_d       = b_q + B_INC;
                        vec_idx_d = vec_idx_q + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    // finish rises on the edge that registers the last check.
                    if (chk_valid && (chk_idx == LAST_IDX)) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            vec_idx_q       <= 16'd0;
            a_q             <= A_INIT;
            b_q             <= B_INIT;
            fail_q          <= 1'b0;
            finish_q        <= 1'b0;
            err_count_q     <= 16'd0;
            first_err_idx_q <= NO_ERR;
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_exp_q[i]   <= '0;
                dl_idx_q[i]   <= 16'd0;
            end
        end else begin
            state_q         <= state_d;
            vec_idx_q       <= vec_idx_d;
            a_q             <= a_d;
            b_q             <= b_d;
            fail_q          <= fail_d;
            finish_q        <= finish_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_valid_q[i] <= dl_valid_d[i];
                dl_exp_q[i]   <= dl_exp_d[i];
                dl_idx_q[i]   <= dl_idx_d[i];
            end
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign fail          = fail_q;
    assign finish        = finish_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_test_logic_vec_checker.sv
// -----------------------------------------------------------------------------
// tb_test_logic_vec_checker
//
// Bench for test_logic_vec_checker. Five checker instances with different
// parameter sets, each attached to a small behavioural DUT built here:
//   u_a : WIDTH 8, OR,  L0, 3 vectors, optional fault when a==4
//   u_b : WIDTH 8, XOR, L2, 4 vectors, 2-stage DUT with corruption/glitch knobs
//   u_c : same as u_b but the checker is told LATENCY=1
//   u_d : WIDTH 4, AND, L0, 3 vectors, wrapping a operand
//   u_e : WIDTH 5, XNOR, L3, 40 vectors, 3-stage DUT with random fault masks
// -----------------------------------------------------------------------------
module tb_test_logic_vec_checker;

    // ---------------------------------------------------------------- clock
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------ instance A
    logic        rst_a = 1'b0, en_a = 1'b0, inj_a = 1'b0;
    logic [7:0]  a_a, b_a, y_a;
    logic        fail_a, fin_a;
    logic [15:0] cnt_a, fidx_a;
    assign y_a = (a_a | b_a) ^ {7'd0, (inj_a && (a_a == 8'd4))};

    test_logic_vec_checker #(.WIDTH(8), .NUM_VEC(3), .LATENCY(0), .OP(1),
        .A_BASE(3), .B_BASE(8), .A_STEP(1), .B_STEP(1)) u_a (
        .clock(clock), .reset(rst_a), .en(en_a), .y(y_a), .a(a_a), .b(b_a),
        .fail(fail_a), .finish(fin_a), .err_count(cnt_a), .first_err_idx(fidx_a));

    // ------------------------------------------------------------ instance B
    logic        rst_b = 1'b0, en_b = 1'b0;
    logic [7:0]  corrupt_b = 8'd0, glitch_b = 8'd0;
    logic [7:0]  a_b, b_b, y_b;
    logic [7:0]  p1_b = 8'd0, p2_b = 8'd0;
    logic        fail_b, fin_b;
    logic [15:0] cnt_b, fidx_b;
    always @(posedge clock) begin
        if (en_b) begin
            p1_b <= (a_b ^ b_b) ^ corrupt_b;
            p2_b <= p1_b;
        end
    end
    assign y_b = p2_b ^ glitch_b;

    test_logic_vec_checker #(.WIDTH(8), .NUM_VEC(4), .LATENCY(2), .OP(2),
        .A_BASE(15), .B_BASE(240), .A_STEP(1), .B_STEP(1)) u_b (
        .clock(clock), .reset(rst_b), .en(en_b), .y(y_b), .a(a_b), .b(b_b),
        .fail(fail_b), .finish(fin_b), .err_count(cnt_b), .first_err_idx(fidx_b));

    // ------------------------------------------------------------ instance C
    logic        rst_c = 1'b0, en_c = 1'b0;
    logic [7:0]  a_c, b_c, y_c;
    logic [7:0]  p1_c = 8'd0, p2_c = 8'd0;
    logic        fail_c, fin_c;
    logic [15:0] cnt_c, fidx_c;
    always @(posedge clock) begin
        if (en_c) begin
            p1_c <= a_c ^ b_c;
            p2_c <= p1_c;
        end
    end
    assign y_c = p2_c;

    test_logic_vec_checker #(.WIDTH(8), .NUM_VEC(4), .LATENCY(1), .OP(2),
        .A_BASE(15), .B_BASE(240), .A_STEP(1), .B_STEP(1)) u_c (
        .clock(clock), .reset(rst_c), .en(en_c), .y(y_c), .a(a_c), .b(b_c),
        .fail(fail_c), .finish(fin_c), .err_count(cnt_c), .first_err_idx(fidx_c));

    // ------------------------------------------------------------ instance D
    logic        rst_d = 1'b0, en_d = 1'b0;
    logic [3:0]  a_d, b_d, y_d;
    logic        fail_d, fin_d;
    logic [15:0] cnt_d, fidx_d;
    assign y_d = a_d & b_d;

    test_logic_vec_checker #(.WIDTH(4), .NUM_VEC(3), .LATENCY(0), .OP(0),
        .A_BASE(15), .B_BASE(15), .A_STEP(1), .B_STEP(0)) u_d (
        .clock(clock), .reset(rst_d), .en(en_d), .y(y_d), .a(a_d), .b(b_d),
        .fail(fail_d), .finish(fin_d), .err_count(cnt_d), .first_err_idx(fidx_d));

    // ------------------------------------------------------------ instance E
    localparam int E_NV = 40;
    localparam int E_L  = 3;
    logic        rst_e = 1'b0, en_e = 1'b0;
    logic [4:0]  inj_e = 5'd0;
    logic [4:0]  a_e, b_e, y_e;
    logic [4:0]  p1_e = 5'd0, p2_e = 5'd0, p3_e = 5'd0;
    logic        fail_e, fin_e;
    logic [15:0] cnt_e, fidx_e;
    always @(posedge clock) begin
        if (en_e) begin
            p1_e <= ~(a_e ^ b_e) ^ inj_e;
            p2_e <= p1_e;
            p3_e <= p2_e;
        end
    end
    assign y_e = p3_e;

    test_logic_vec_checker #(.WIDTH(5), .NUM_VEC(E_NV), .LATENCY(E_L), .OP(3),
        .A_BASE(27), .B_BASE(9), .A_STEP(7), .B_STEP(13)) u_e (
        .clock(clock), .reset(rst_e), .en(en_e), .y(y_e), .a(a_e), .b(b_e),
        .fail(fail_e), .finish(fin_e), .err_count(cnt_e), .first_err_idx(fidx_e));

    // --------------------------------------------------------- model helpers
    // Operand k of an arithmetic sequence, reduced mod 2^w.
    function automatic int seq_val(int base, int step, int k, int w);
        return (base + k * step) % (1 << w);
    endfunction

    function automatic int ref_op(int op, int x, int z, int w);
        int m;
        m = (1 << w) - 1;
        case (op)
            0:       return x & z;
            1:       return x | z;
            2:       return x ^ z;
            default: return (~(x ^ z)) & m;
        endcase
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b0; en_d = 1'b1; en_e = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if (fail_a !== 1'b0) begin failures++; $display("FAIL reset_fail_a actual=%0d expected=0", fail_a); end
        checks++;
        if (fin_a !== 1'b0) begin failures++; $display("FAIL reset_finish_a actual=%0d expected=0", fin_a); end
        checks++;
        if (cnt_a !== 16'd0) begin failures++; $display("FAIL reset_err_count_a actual=%0d expected=0", cnt_a); end
        checks++;
        if (fidx_a !== 16'hFFFF) begin failures++; $display("FAIL reset_first_idx_a actual=%0h expected=ffff", fidx_a); end
        checks++;
        if (a_a !== 8'd3 || b_a !== 8'd8) begin failures++; $display("FAIL reset_ab_a actual=%0d/%0d expected=3/8", a_a, b_a); end
        checks++;
        if (a_b !== 8'h0F || b_b !== 8'hF0) begin failures++; $display("FAIL reset_ab_b actual=%0h/%0h expected=f/f0", a_b, b_b); end
        checks++;
        if (a_d !== 4'hF || b_d !== 4'hF) begin failures++; $display("FAIL reset_ab_d actual=%0h/%0h expected=f/f", a_d, b_d); end
        checks++;
        if (a_e !== 5'd27 || b_e !== 5'd9) begin failures++; $display("FAIL reset_ab_e actual=%0d/%0d expected=27/9", a_e, b_e); end
        checks++;
        if (fidx_e !== 16'hFFFF || fin_e !== 1'b0) begin failures++; $display("FAIL reset_e actual=%0h/%0d expected=ffff/0", fidx_e, fin_e); end
        checks++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0; rst_e = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_d = 1'b0;
    endtask

    task automatic test_or_golden();
        int ea, eb;
        inj_a = 1'b0; rst_a = 1'b1; en_a = 1'b0;
        @(posedge clock); #1;
        rst_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ea = seq_val(3, 1, k, 8);
            eb = seq_val(8, 1, k, 8);
            if (a_a !== 8'(ea) || b_a !== 8'(eb)) begin failures++; $display("FAIL or_operands k=%0d actual=%0d/%0d expected=%0d/%0d", k, a_a, b_a, ea, eb); end
            checks++;
            if (y_a !== 8'(ref_op(1, ea, eb, 8))) begin failures++; $display("FAIL or_y k=%0d actual=%0d expected=%0d", k, y_a, ref_op(1, ea, eb, 8)); end
            checks++;
            if (fin_a !== 1'b0) begin failures++; $display("FAIL or_early_finish k=%0d actual=%0d expected=0", k, fin_a); end
            checks++;
            en_a = 1'b1;
            @(posedge clock); #1;
        end
        en_a = 1'b0;
        if (fin_a !== 1'b1) begin failures++; $display("FAIL or_finish actual=%0d expected=1", fin_a); end
        checks++;
        if (fail_a !== 1'b0 || cnt_a !== 16'd0 || fidx_a !== 16'hFFFF) begin
            failures++; $display("FAIL or_clean actual=%0d/%0d/%0h expected=0/0/ffff", fail_a, cnt_a, fidx_a);
        end
        checks++;
        // DONE ignores en: operands keep holding the last vector.
        en_a = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        en_a = 1'b0;
        if (a_a !== 8'd5 || b_a !== 8'd10 || fin_a !== 1'b1) begin
            failures++; $display("FAIL or_done_hold actual=%0d/%0d/%0d expected=5/10/1", a_a, b_a, fin_a);
        end
        checks++;
    endtask

    task automatic test_or_fault();
        int exp_err, exp_first;
        inj_a = 1'b1; rst_a = 1'b1; en_a = 1'b0;
        @(posedge clock); #1;
        rst_a = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            en_a = 1'b1;
            @(posedge clock); #1;
            exp_err = 0; exp_first = 16'hFFFF;
            for (int k = 0; k < n; k++) begin
                if (seq_val(3, 1, k, 8) == 4) begin
                    if (exp_err == 0) exp_first = k;
                    exp_err++;
                end
            end
            if (fail_a !== (exp_err > 0)) begin failures++; $display("FAIL fault_fail n=%0d actual=%0d expected=%0d", n, fail_a, exp_err > 0); end
            checks++;
            if (cnt_a !== 16'(exp_err)) begin failures++; $display("FAIL fault_count n=%0d actual=%0d expected=%0d", n, cnt_a, exp_err); end
            checks++;
            if (fidx_a !== 16'(exp_first)) begin failures++; $display("FAIL fault_first n=%0d actual=%0h expected=%0h", n, fidx_a, exp_first); end
            checks++;
            if (fin_a !== (n >= 3)) begin failures++; $display("FAIL fault_finish n=%0d actual=%0d expected=%0d", n, fin_a, n >= 3); end
            checks++;
        end
        en_a = 1'b0; inj_a = 1'b0;
    endtask

    task automatic test_latency2();
        int n;
        corrupt_b = 8'd0; glitch_b = 8'd0;
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clock); #1;
        rst_b = 1'b0; en_b = 1'b1;
        n = 0;
        while (fin_b !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        en_b = 1'b0;
        if (n != 4 + 2) begin failures++; $display("FAIL lat2_finish_cycles actual=%0d expected=6", n); end
        checks++;
        if (fail_b !== 1'b0 || cnt_b !== 16'd0) begin failures++; $display("FAIL lat2_clean actual=%0d/%0d expected=0/0", fail_b, cnt_b); end
        checks++;
        if (a_b !== 8'(seq_val(15, 1, 3, 8))) begin failures++; $display("FAIL lat2_hold_a actual=%0h expected=%0h", a_b, seq_val(15, 1, 3, 8)); end
        checks++;
    endtask

    task automatic test_latency_miscfg();
        int n, exp_err, prev, cur;
        rst_c = 1'b1; en_c = 1'b0;
        @(posedge clock); #1;
        rst_c = 1'b0; en_c = 1'b1;
        n = 0;
        while (fin_c !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        en_c = 1'b0;
        // The DUT is really two deep, so vector k is compared against the
        // result for vector k-1 (an idle, zeroed pipeline before vector 0).
        exp_err = 0; prev = 0;
        for (int k = 0; k < 4; k++) begin
            cur = ref_op(2, seq_val(15, 1, k, 8), seq_val(240, 1, k, 8), 8);
            if (cur != prev) exp_err++;
            prev = cur;
        end
        if (n != 4 + 1) begin failures++; $display("FAIL miscfg_finish_cycles actual=%0d expected=5", n); end
        checks++;
        if (fail_c !== 1'b1) begin failures++; $display("FAIL miscfg_fail actual=%0d expected=1", fail_c); end
        checks++;
        if (fidx_c !== 16'd0) begin failures++; $display("FAIL miscfg_first actual=%0h expected=0", fidx_c); end
        checks++;
        if (cnt_c !== 16'(exp_err)) begin failures++; $display("FAIL miscfg_count actual=%0d expected=%0d", cnt_c, exp_err); end
        checks++;
    endtask

    task automatic test_wrap();
        int ea, eb;
        rst_d = 1'b1; en_d = 1'b0;
        @(posedge clock); #1;
        rst_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ea = seq_val(15, 1, k, 4);
            eb = seq_val(15, 0, k, 4);
            if (a_d !== 4'(ea) || b_d !== 4'(eb)) begin failures++; $display("FAIL wrap_operands k=%0d actual=%0d/%0d expected=%0d/%0d", k, a_d, b_d, ea, eb); end
            checks++;
            if (y_d !== 4'(ref_op(0, ea, eb, 4))) begin failures++; $display("FAIL wrap_y k=%0d actual=%0d expected=%0d", k, y_d, ref_op(0, ea, eb, 4)); end
            checks++;
            en_d = 1'b1;
            @(posedge clock); #1;
        end
        en_d = 1'b0;
        if (fin_d !== 1'b1 || fail_d !== 1'b0 || cnt_d !== 16'd0) begin
            failures++; $display("FAIL wrap_result actual=%0d/%0d/%0d expected=1/0/0", fin_d, fail_d, cnt_d);
        end
        checks++;
    endtask

    task automatic test_en_stall();
        int total;
        corrupt_b = 8'd0; glitch_b = 8'd0;
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clock); #1;
        rst_b = 1'b0;
        en_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total = 2;
        // Stall: y is deliberately wrong, but nothing may be compared.
        en_b = 1'b0; glitch_b = 8'hA5;
        for (int s = 0; s < 3; s++) begin
            @(posedge clock); #1;
            total++;
            if (a_b !== 8'(seq_val(15, 1, 2, 8)) || b_b !== 8'(seq_val(240, 1, 2, 8))) begin
                failures++; $display("FAIL stall_hold s=%0d actual=%0h/%0h expected=%0h/%0h", s, a_b, b_b, seq_val(15, 1, 2, 8), seq_val(240, 1, 2, 8));
            end
            checks++;
            if (cnt_b !== 16'd0 || fail_b !== 1'b0 || fin_b !== 1'b0) begin
                failures++; $display("FAIL stall_no_check s=%0d actual=%0d/%0d/%0d expected=0/0/0", s, cnt_b, fail_b, fin_b);
            end
            checks++;
        end
        glitch_b = 8'd0; en_b = 1'b1;
        while (fin_b !== 1'b1 && total < 40) begin
            @(posedge clock); #1;
            total++;
        end
        en_b = 1'b0;
        if (total != 4 + 2 + 3) begin failures++; $display("FAIL stall_finish_cycles actual=%0d expected=9", total); end
        checks++;
        if (fail_b !== 1'b0) begin failures++; $display("FAIL stall_clean actual=%0d expected=0", fail_b); end
        checks++;
    endtask

    task automatic test_reset_midrun();
        int n;
        corrupt_b = 8'hFF; glitch_b = 8'd0;
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clock); #1;
        rst_b = 1'b0; en_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        // Vector 2 is presented; its edge would retire vector 0's (bad) check,
        // but reset wins over en.
        rst_b = 1'b1;
        @(posedge clock); #1;
        rst_b = 1'b0; en_b = 1'b0;
        if (cnt_b !== 16'd0 || fail_b !== 1'b0) begin failures++; $display("FAIL midrst_clear actual=%0d/%0d expected=0/0", cnt_b, fail_b); end
        checks++;
        if (a_b !== 8'h0F || fidx_b !== 16'hFFFF || fin_b !== 1'b0) begin
            failures++; $display("FAIL midrst_state actual=%0h/%0h/%0d expected=f/ffff/0", a_b, fidx_b, fin_b);
        end
        checks++;
        // Golden rerun: the DUT still holds corrupted data, which must only
        // meet empty delay-line slots.
        corrupt_b = 8'd0; en_b = 1'b1;
        n = 0;
        while (fin_b !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        en_b = 1'b0;
        if (n != 6) begin failures++; $display("FAIL midrst_rerun_cycles actual=%0d expected=6", n); end
        checks++;
        if (fail_b !== 1'b0 || cnt_b !== 16'd0) begin failures++; $display("FAIL midrst_rerun_clean actual=%0d/%0d expected=0/0", fail_b, cnt_b); end
        checks++;
    endtask

    task automatic test_random();
        bit          faulted [E_NV];
        logic [4:0]  mask    [E_NV];
        int n, cyc, kk, exp_err, exp_first;
        for (int run = 0; run < 3; run++) begin
            for (int k = 0; k < E_NV; k++) begin
                faulted[k] = ($urandom_range(0, 5) == 0);
                mask[k]    = 5'($urandom_range(1, 31));
            end
            inj_e = 5'd0; rst_e = 1'b1; en_e = 1'b0;
            @(posedge clock); #1;
            rst_e = 1'b0;
            n = 0; cyc = 0;
            while (n < E_NV + E_L + 2 && cyc < 2000) begin
                kk = (n < E_NV) ? n : E_NV - 1;
                inj_e = (n < E_NV && faulted[n]) ? mask[n] : 5'd0;
                // A vector's check retires on the (k+L+1)-th enabled edge.
                exp_err = 0; exp_first = 16'hFFFF;
                for (int j = 0; j < E_NV && j <= n - E_L - 1; j++) begin
                    if (faulted[j]) begin
                        if (exp_err == 0) exp_first = j;
                        exp_err++;
                    end
                end
                if (a_e !== 5'(seq_val(27, 7, kk, 5)) || b_e !== 5'(seq_val(9, 13, kk, 5))) begin
                    failures++; $display("FAIL rnd_operands run=%0d n=%0d actual=%0d/%0d expected=%0d/%0d", run, n, a_e, b_e, seq_val(27, 7, kk, 5), seq_val(9, 13, kk, 5));
                end
                checks++;
                if (fin_e !== (n >= E_NV + E_L)) begin failures++; $display("FAIL rnd_finish run=%0d n=%0d actual=%0d expected=%0d", run, n, fin_e, n >= E_NV + E_L); end
                checks++;
                if (cnt_e !== 16'(exp_err)) begin failures++; $display("FAIL rnd_count run=%0d n=%0d actual=%0d expected=%0d", run, n, cnt_e, exp_err); end
                checks++;
                if (fail_e !== (exp_err > 0)) begin failures++; $display("FAIL rnd_fail run=%0d n=%0d actual=%0d expected=%0d", run, n, fail_e, exp_err > 0); end
                checks++;
                if (fidx_e !== 16'(exp_first)) begin failures++; $display("FAIL rnd_first run=%0d n=%0d actual=%0h expected=%0h", run, n, fidx_e, exp_first); end
                checks++;
                en_e = ($urandom_range(0, 3) != 0);
                @(posedge clock); #1;
                if (en_e) n++;
                cyc++;
            end
            en_e = 1'b0; inj_e = 5'd0;
            if (cyc >= 2000) begin failures++; $display("FAIL rnd_timeout run=%0d actual=%0d expected<2000", run, cyc); end
            checks++;
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_or_golden();
        test_or_fault();
        test_latency2();
        test_latency_miscfg();
        test_wrap();
        test_en_stall();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
